// File: rtl/intr_pulse_gen_mc.sv
// Multi-channel periodic / one-shot interrupt pulse generator with deferred
// period updates and sticky per-channel status flags.
module intr_pulse_gen_mc #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int PULSE_W    = 1,
  parameter int DEF_PERIOD = 100000
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                           cfg_period,
  input  logic [N_CH-1:0]                            enable,
  input  logic [N_CH-1:0]                            oneshot,
  input  logic [N_CH-1:0]                            irq_clr,
  output logic [N_CH-1:0]                            pulse,
  output logic [N_CH-1:0]                            irq_status
);

  localparam int              CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] PW_C  = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] DEF_C = CNT_W'(DEF_PERIOD);

  for (genvar gi = 0; gi < N_CH; gi++) begin : ch_g
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [CNT_W-1:0] period_r, period_n;
    logic [CNT_W-1:0] pend_val_r, pend_val_n;
    logic             pend_r, pend_n;
    logic             run_r, done_r, done_n;
    logic             pulse_r, pulse_n, pulse_d_r;
    logic             stat_r, stat_n;
    logic [7:0]       pw_left_r, pw_left_n;
    logic             wr_s, tc_s, set_s, live_s;
    logic [CNT_W-1:0] wmin_s;

    // run_r marks that enable was already high on the previous edge, so the
    // first enabled edge only arms the channel and pulses land at t0+P.
    assign wr_s   = cfg_we && (cfg_ch == CH_W'(gi));
    assign live_s = run_r && !done_r && (period_r != {CNT_W{1'b0}});
    assign tc_s   = enable[gi] && live_s && (cnt_r == period_r - CNT_W'(1));
    assign wmin_s = (period_r < PW_C) ? period_r : PW_C;
    assign set_s  = pulse_r && !pulse_d_r;

    // Per-channel next-state: counter, period update, pulse timer, status.
    always_comb begin
      cnt_n      = cnt_r;
      period_n   = period_r;
      pend_val_n = pend_val_r;
      pend_n     = pend_r;
      done_n     = done_r;
      pulse_n    = pulse_r;
      pw_left_n  = pw_left_r;
      stat_n     = set_s | (stat_r & ~irq_clr[gi]);
      if (!enable[gi]) begin
        cnt_n     = {CNT_W{1'b0}};
        done_n    = 1'b0;
        pulse_n   = 1'b0;
        pw_left_n = 8'd0;
        if (wr_s) begin
          period_n = cfg_period;
        end else begin
          period_n = period_r;
        end
      end else begin
        if (tc_s) begin
          cnt_n     = {CNT_W{1'b0}};
          pulse_n   = 1'b1;
          pw_left_n = 8'(wmin_s - CNT_W'(1));
          done_n    = oneshot[gi];
          pend_n    = 1'b0;
          if (pend_r) begin
            period_n = pend_val_r;
          end else begin
            period_n = period_r;
          end
        end else begin
          if (live_s) begin
            cnt_n = cnt_r + CNT_W'(1);
          end else begin
            cnt_n = {CNT_W{1'b0}};
          end
          if (pw_left_r != 8'd0) begin
            pw_left_n = pw_left_r - 8'd1;
          end else begin
            pulse_n = 1'b0;
          end
        end
        // A write landing on the wrap edge waits for the following wrap.
        if (wr_s) begin
          pend_val_n = cfg_period;
          pend_n     = 1'b1;
        end else begin
          pend_val_n = pend_val_r;
        end
      end
    end

    // Per-channel state register with synchronous reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_r      <= {CNT_W{1'b0}};
        period_r   <= DEF_C;
        pend_val_r <= {CNT_W{1'b0}};
        pend_r     <= 1'b0;
        run_r      <= 1'b0;
        done_r     <= 1'b0;
        pulse_r    <= 1'b0;
        pulse_d_r  <= 1'b0;
        stat_r     <= 1'b0;
        pw_left_r  <= 8'd0;
      end else begin
        cnt_r      <= cnt_n;
        period_r   <= period_n;
        pend_val_r <= pend_val_n;
        pend_r     <= pend_n;
        run_r      <= enable[gi];
        done_r     <= done_n;
        pulse_r    <= pulse_n;
        pulse_d_r  <= pulse_r;
        stat_r     <= stat_n;
        pw_left_r  <= pw_left_n;
      end
    end

    assign pulse[gi]      = pulse_r;
    assign irq_status[gi] = stat_r;
  end

endmodule
